// File: rtl/logic_rule_extractor.sv
// ---------------------------------------------------------------------------
// logic_rule_extractor
//
// Purpose:
//   Characterises a 3-input, 1-output logic block and recovers its 8-bit rule
//   code. Each of the eight input vectors is driven onto the block in turn,
//   held for a settle interval, and then sampled several times. A majority
//   vote of those samples gives that vector's output bit. The bit for vector
//   000 lands in rule[7] and the bit for vector 111 lands in rule[0], so the
//   result reads the same way as the names of the truth-table modules.
//
// Parameters:
//   SETTLE_CYCLES  cycles a vector is held before sampling starts (1..255)
//   SAMPLES        samples taken per vector, must be odd (1..15)
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   start       one-cycle sweep request, honoured only in IDLE
//   expected    reference rule code, captured when a start is accepted
//   probe       vector {in1,in2,in3} driven to the block under test
//   dut_out     output of the block under test (already synchronous to clk)
//   busy        high while a sweep is driving or sampling
//   rule        recovered rule code
//   rule_valid  result-available handshake
//   rule_ready  consumer accepts the result
//   glitch      sticky per sweep; some vector's samples disagreed
//   match       rule equals the captured expected code (valid with rule_valid)
// ---------------------------------------------------------------------------
module logic_rule_extractor #(
    parameter int SETTLE_CYCLES = 4,
    parameter int SAMPLES       = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] expected,
    output logic [2:0] probe,
    input  logic       dut_out,
    output logic       busy,
    output logic [7:0] rule,
    output logic       rule_valid,
    input  logic       rule_ready,
    output logic       glitch,
    output logic       match
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    // The settle counter is loaded with N-1 and counts down to zero, so the
    // DRIVE state lasts exactly SETTLE_CYCLES cycles.
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] SAMPLE_LAST = 4'(SAMPLES - 1);
    localparam logic [3:0] SAMPLE_HALF = 4'(SAMPLES / 2);
    localparam logic [3:0] SAMPLE_ALL  = 4'(SAMPLES);

    state_t     state;
    state_t     next_state;
    logic [2:0] k;
    logic [7:0] settle_cnt;
    logic [3:0] sample_cnt;
    logic [3:0] ones_cnt;
    logic [7:0] expected_q;

    logic       last_sample;
    logic [3:0] ones_total;
    logic       majority;
    logic       disagree;

    // The ones count including the sample being taken this cycle, so the
    // decision on the last sample cycle sees all SAMPLES values.
    assign last_sample = (state == SAMPLE) && (sample_cnt == SAMPLE_LAST);
    assign ones_total  = ones_cnt + 4'(dut_out);
    assign majority    = (ones_total > SAMPLE_HALF);
    assign disagree    = (ones_total != 4'd0) && (ones_total != SAMPLE_ALL);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and state-derived outputs. The probe is forced back
    // to 000 outside an active sweep so the block under test sees a known
    // vector while idle or waiting on the consumer.
    always_comb begin
        next_state = state;
        probe      = 3'b000;
        busy       = 1'b0;
        rule_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    next_state = DRIVE;
                end
            end
            DRIVE: begin
                probe = k;
                busy  = 1'b1;
                if (settle_cnt == 8'd0) begin
                    next_state = SAMPLE;
                end
            end
            SAMPLE: begin
                probe = k;
                busy  = 1'b1;
                if (last_sample) begin
                    next_state = (k == 3'd7) ? DONE : DRIVE;
                end
            end
            DONE: begin
                rule_valid = 1'b1;
                if (rule_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Only meaningful while the result is presented; held low otherwise so
    // it never flags a stale or partial rule.
    assign match = rule_valid && (rule == expected_q);

    // Sweep datapath: vector index, settle/sample/ones counters, the rule
    // being assembled and the sticky glitch flag. rule and glitch are left
    // alone in DONE and IDLE so the last result survives the handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            k          <= 3'd0;
            settle_cnt <= 8'd0;
            sample_cnt <= 4'd0;
            ones_cnt   <= 4'd0;
            rule       <= 8'h00;
            glitch     <= 1'b0;
            expected_q <= 8'h00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        k          <= 3'd0;
                        settle_cnt <= SETTLE_LOAD;
                        sample_cnt <= 4'd0;
                        ones_cnt   <= 4'd0;
                        rule       <= 8'h00;
                        glitch     <= 1'b0;
                        expected_q <= expected;
                    end
                end
                DRIVE: begin
                    if (settle_cnt != 8'd0) begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                SAMPLE: begin
                    if (last_sample) begin
                        rule[3'd7 - k] <= majority;
                        if (disagree) begin
                            glitch <= 1'b1;
                        end
                        sample_cnt <= 4'd0;
                        ones_cnt   <= 4'd0;
                        if (k != 3'd7) begin
                            k          <= k + 3'd1;
                            settle_cnt <= SETTLE_LOAD;
                        end
                    end else begin
                        sample_cnt <= sample_cnt + 4'd1;
                        ones_cnt   <= ones_total;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/logic_rule_extractor.md
Name: logic_rule_extractor

Overview:
- Characterises a 3-input, 1-output logic block and recovers its 8-bit rule code, the same code used to name the truth-table modules.
- The extractor drives each input combination onto the block under test, waits for the output to settle, samples it, and assembles the rule code.
- Used on the bench and in hardware-in-loop checks to confirm that a synthesised or measured gate matches its intended function.

Parameters:
- SETTLE_CYCLES, 4: cycles a probe vector is held before sampling begins; legal range 1..255.
- SAMPLES, 3: samples taken per vector; must be odd; legal range 1..15.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- expected  input  8  rule code to compare against; captured on an accepted start.
- probe  output  3  drive vector {in1,in2,in3} to the block under test.
- dut_out  input  1  output of the block under test.
- busy  output  1  high from the cycle after an accepted start until DONE is entered.
- rule  output  8  recovered rule code.
- rule_valid  output  1  result-available handshake.
- rule_ready  input  1  consumer accepts the result.
- glitch  output  1  sticky per sweep; set if any vector's samples disagreed.
- match  output  1  rule == captured expected; meaningful only while rule_valid is high.

Behaviour:
- Reset (synchronous, active-high, any state including mid-sweep) forces:
  - state IDLE;
  - probe=000, busy=0, rule=8'h00, rule_valid=0, glitch=0, match=0;
  - counters=0.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - probe=000.
  - start=1 moves to DRIVE with vector index k=0, settle counter loaded, glitch cleared, rule cleared, expected captured.
- DRIVE:
  - probe=k, busy=1.
  - Stay for exactly SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE:
  - probe=k held.
  - Sample dut_out on each of SAMPLES consecutive cycles; count ones.
  - On the last sample cycle, write rule[7-k] = 1 when ones > SAMPLES/2 (majority).
  - If 0 < ones < SAMPLES, set glitch.
  - If k==7, go to DONE. Otherwise k=k+1 and go to DRIVE (no idle cycle between vectors).
- Bit order is MSB-first: rule[7] is the output for vector 000 and rule[0] is the output for vector 111.
- DONE:
  - busy=0, rule_valid=1, probe=000.
  - rule, glitch and match hold stable while rule_valid is high.
  - rule_valid && rule_ready returns to IDLE on the next cycle with rule_valid=0.
  - rule and glitch retain their values in IDLE until the next accepted start.
- Latency: if start is sampled high at cycle 0, busy is high from cycle 1 and rule_valid rises at cycle 1 + 8*(SETTLE_CYCLES+SAMPLES). With the defaults this is cycle 57.
- start is ignored in DRIVE, SAMPLE and DONE, including on the handshake cycle itself. A new sweep needs start while in IDLE.
- rule_ready is ignored outside DONE.
- Counter widths: settle counter 8 bits, sample counter and ones counter 4 bits, k 3 bits. There is no wrap, because transitions happen at terminal counts.
- dut_out is treated as already synchronous to clk. Synchronisation, if needed, is external.

Test Plan:
- Block under test modelled as table 000→0, 001→0, 010→1, 011→1, 100→1, 101→1, 110→0, 111→1; pulse start → probe steps 0..7, rule_valid at cycle 57, rule=8'h3D, glitch=0; with expected=8'h3D, match=1.
- dut_out tied 1, expected=8'h00 → rule=8'hFF, match=0. With dut_out tied 0 → rule=8'h00.
- Same table as the first test, but dut_out forced to the wrong value on the first sample of vector 011 only (SAMPLES=3) → rule still 8'h3D, glitch=1.
- Hold rule_ready=0 for 10 cycles after rule_valid and pulse start meanwhile → rule_valid stays high, values stable, no new sweep. Raise rule_ready → IDLE next cycle. A later start runs a full sweep with glitch cleared.
- Assert reset while in SAMPLE at k=4 → next cycle all outputs at reset values, state IDLE. A subsequent start sweeps from k=0.
- SETTLE_CYCLES=1, SAMPLES=1 → each vector held 2 cycles, rule_valid at cycle 17, rule correct for an XOR3 model (8'h69).
